// File: rtl/mdu_pkg.sv
// Shared constants for the RV32M multiply/divide unit: operand width,
// funct3 opcodes, FSM state encoding and operand-signedness decode.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FAST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic logic f3_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] divisor_i,
  input  logic         dividend_bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // rem_i < divisor_i always holds, so a non-negative diff fits in W bits.
  always_comb begin
    shifted = {rem_i, dividend_bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = ~diff[W];
    rem_o   = q_bit_o ? diff[W-1:0] : {rem_i[W-2:0], dividend_bit_i};
  end

endmodule

// File: rtl/riscv_mdu.sv
// Iterative radix-2 RV32M multiply/divide unit. Operands are reduced to
// magnitudes at accept; the sign is restored on the transition into DONE.
module riscv_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Accept-time operand conditioning.
  logic            accept;
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && !flush;
    sgn_a    = f3_signed_a(funct3) & op_a[XLEN-1];
    sgn_b    = f3_signed_b(funct3) & op_b[XLEN-1];
    mag_a    = sgn_a ? -op_a : op_a;
    mag_b    = sgn_b ? -op_b : op_b;
    div_zero = (op_b == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (op_a == INT_MIN) && (op_b == ALL_ONES);
    // funct3[1] separates remainder ops from quotient ops.
    if (div_zero) fast_res = funct3[1] ? op_a : ALL_ONES;
    else          fast_res = funct3[1] ? '0   : INT_MIN;
  end

  // Shift-add multiply: acc holds {partial product, remaining multiplier}.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] mul_prod;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & opnd_q};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    mul_prod = (neg_a_q ^ neg_b_q) ? -mul_next : mul_next;
  end

  // Restoring divide: acc holds {remainder, dividend shifting into quotient}.
  logic [XLEN-1:0]   div_rem;
  logic              div_qbit;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   div_quo, div_rmd;

  mdu_div_step #(.W(XLEN)) u_div_step (
    .rem_i          (acc_q[2*XLEN-1:XLEN]),
    .divisor_i      (opnd_q),
    .dividend_bit_i (acc_q[XLEN-1]),
    .rem_o          (div_rem),
    .q_bit_o        (div_qbit)
  );

  always_comb begin
    div_next = {div_rem, acc_q[XLEN-2:0], div_qbit};
    div_quo  = (neg_a_q ^ neg_b_q) ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    div_rmd  = neg_a_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
  end

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          cnt_d   = '0;
          f3_d    = funct3;
          neg_a_d = sgn_a;
          neg_b_d = sgn_b;
          if (!funct3[2]) begin
            state_d = S_MUL;
            opnd_d  = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
          end else if (div_zero || div_ovf) begin
            state_d = S_FAST;
            opnd_d  = mag_b;
            acc_d   = {{XLEN{1'b0}}, fast_res};
          end else begin
            state_d = S_DIV;
            opnd_d  = mag_b;
            acc_d   = {{XLEN{1'b0}}, mag_a};
          end
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = S_DONE;
            result_d = (f3_q == F3_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
          end
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = S_DONE;
            result_d = f3_q[1] ? div_rmd : div_quo;
          end
        end
      end
      S_FAST: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          result_d = acc_q[XLEN-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      f3_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      f3_q     <= f3_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FAST);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_riscv_mdu.sv
// Directed bench for riscv_mdu: arithmetic results, latency, fast paths,
// flush, mid-op reset and back-to-back issue.
module tb_riscv_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  always #5 clk = ~clk;

  riscv_mdu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then scramble the inputs.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    funct3 = 3'b111;
    op_a   = 32'hDEAD_BEEF;
    op_b   = 32'h0;
  endtask

  // Starts in the cycle after the accept edge (cycle k+1); returns the cycle
  // index in which done was seen (100 on timeout).
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic run_table(input vec_t v[$]);
    int lat;
    bit ok;
    foreach (v[i]) begin
      issue(v[i].f, v[i].a, v[i].b);
      wait_done(lat, ok);
      checks++;
      if (lat != v[i].lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
      end
      checks++;
      if (result !== v[i].exp) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", v[i].name, result, v[i].exp);
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s busy: got irregular busy/done expected busy until done", v[i].name);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset result: got %h expected 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back('{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_x_m3"});
    v.push_back('{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max"});
    v.push_back('{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min_sq"});
    v.push_back('{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu_m1_x_2"});
    run_table(v);
  endtask

  task automatic test_div();
    vec_t v[$];
    v.push_back('{F3_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div_m7_2"});
    v.push_back('{F3_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem_m7_2"});
    v.push_back('{F3_DIVU, 32'd100,      32'd7, 32'd14,       33, "divu_100_7"});
    v.push_back('{F3_REMU, 32'd100,      32'd7, 32'd2,        33, "remu_100_7"});
    run_table(v);
  endtask

  task automatic test_fast();
    vec_t v[$];
    v.push_back('{F3_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 2, "divu_by_zero"});
    v.push_back('{F3_REMU, 32'd5,        32'd0,        32'd5,        2, "remu_by_zero"});
    v.push_back('{F3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, "div_overflow"});
    v.push_back('{F3_REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        2, "rem_overflow"});
    run_table(v);
  endtask

  task automatic test_flush();
    int  lat;
    bit  ok;
    bit  seen_done;
    issue(F3_DIVU, 32'd100, 32'd7);
    wait_done(lat, ok);
    checks++;
    if (result !== 32'd14) begin errors++; $display("FAIL flush_setup result: got %h expected %h", result, 32'd14); end
    tick();
    issue(F3_MUL, 32'd5, 32'd5);
    repeat (9) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL flush_pre busy: got %b expected 1", busy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_post busy: got %b expected 0", busy); end
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done) begin errors++; $display("FAIL flush_nodone done: got pulse expected none"); end
    checks++;
    if (result !== 32'd14) begin errors++; $display("FAIL flush_hold result: got %h expected %h", result, 32'd14); end
    // Flush and start together while idle: flush wins.
    funct3 = F3_MUL;
    op_a   = 32'd2;
    op_b   = 32'd2;
    start  = 1'b1;
    flush  = 1'b1;
    tick();
    start  = 1'b0;
    flush  = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    issue(F3_MUL, 32'd7, 32'd3);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b expected 0", busy); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL rstmid result: got %h expected 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done) begin errors++; $display("FAIL rstmid_nodone done: got pulse expected none"); end
  endtask

  task automatic test_back_to_back();
    int          d1 = 0;
    int          d2 = 0;
    logic [31:0] r1 = '0;
    logic [31:0] r2 = '0;
    logic        b34 = 1'b0;
    funct3 = F3_MUL;
    op_a   = 32'd3;
    op_b   = 32'd4;
    start  = 1'b1;
    tick();
    for (int c = 1; c <= 80; c++) begin
      if (c == 10) op_a = 32'd5;
      if (c == 34) b34 = busy;
      if (done === 1'b1) begin
        if (d1 == 0) begin
          d1 = c;
          r1 = result;
        end else if (d2 == 0) begin
          d2 = c;
          r2 = result;
          start = 1'b0;
        end
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (d1 != 33) begin errors++; $display("FAIL b2b_first latency: got %0d expected 33", d1); end
    checks++;
    if (r1 !== 32'd12) begin errors++; $display("FAIL b2b_first result: got %h expected %h", r1, 32'd12); end
    checks++;
    if (b34 !== 1'b1) begin errors++; $display("FAIL b2b_accept busy: got %b expected 1", b34); end
    checks++;
    if (d2 != 66) begin errors++; $display("FAIL b2b_second latency: got %0d expected 66", d2); end
    checks++;
    if (r2 !== 32'd20) begin errors++; $display("FAIL b2b_second result: got %h expected %h", r2, 32'd20); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
